// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin scheduler that feeds echo bytes and message packets to a UART transmitter
//
// Ports:
//   clk          system clock, rising-edge synchronous
//   reset        synchronous active-high reset
//   echo_valid   one-cycle push strobe for echo_data into the echo buffer
//   echo_data    echo byte
//   msg_valid    message source presents msg_data
//   msg_data     message byte
//   msg_last     final byte of the current message packet
//   msg_ready    byte accepted this cycle (valid && ready), only ever high in ARB
//   tx_start     one-cycle start pulse to the transmitter
//   tx_data      registered byte for the transmitter, held until the next load
//   tx_busy      transmitter busy flag
//   echo_drop    one-cycle pulse when an echo byte is discarded on a full buffer
//   o_state      FSM state for debug LEDs (ARB=0, ISSUE=1, WAIT_HI=2, WAIT_LO=3)
//
// Build option: UART_TX_SCHED_ECHO_FIFO_EN selects a 4-entry echo FIFO;
// left undefined, the echo buffer is a single holding register.
module uart_tx_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       echo_valid,
    input  logic [7:0] echo_data,
    input  logic       msg_valid,
    input  logic [7:0] msg_data,
    input  logic       msg_last,
    output logic       msg_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       echo_drop,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {ARB = 2'd0, ISSUE = 2'd1, WAIT_HI = 2'd2, WAIT_LO = 2'd3} state_t;
    state_t     r_state, w_next_state;
    logic       r_prio_msg, r_pkt_open, r_echo_drop;
    logic [1:0] r_tmo;
    logic [7:0] r_tx_data;
    logic       w_empty, w_full, w_push, w_pop, w_drop;
    logic       w_arb_go, w_sel_msg, w_sel_echo;
    logic [7:0] w_head;

    // An open message packet locks out the echo source until its last byte.
    assign w_arb_go   = (r_state == ARB) && !tx_busy && !reset;
    assign w_sel_msg  = msg_valid && (r_pkt_open || w_empty || r_prio_msg);
    assign w_sel_echo = !w_empty && !r_pkt_open && !w_sel_msg;
    assign w_pop      = w_arb_go && w_sel_echo;
    assign msg_ready  = w_arb_go && w_sel_msg;
    // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
    assign w_push     = echo_valid && (!w_full || w_pop);
    assign w_drop     = echo_valid && w_full && !w_pop;

`ifdef UART_TX_SCHED_ECHO_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_count;
    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == 3'd4);
    assign w_head  = r_mem[r_rd_ptr];
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= echo_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'd0, w_push} - {2'd0, w_pop};
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_count;
    assign w_empty = !r_count;
    assign w_full  = r_count;
    assign w_head  = r_hold;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 1'b0;
        end else begin
            if (w_push)
                r_hold <= echo_data;
            r_count <= w_push ? 1'b1 : (w_pop ? 1'b0 : r_count);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ARB;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        tx_start     = 1'b0;
        case (r_state)
            ARB:     w_next_state = (w_pop || msg_ready) ? ISSUE : ARB;
            ISSUE: begin
                tx_start     = 1'b1;
                w_next_state = WAIT_HI;
            end
            // Give up on a transmitter that never raises busy after 4 cycles.
            WAIT_HI: w_next_state = tx_busy ? WAIT_LO : ((r_tmo == 2'd3) ? ARB : WAIT_HI);
            WAIT_LO: w_next_state = tx_busy ? WAIT_LO : ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_data   <= 8'h00;
            r_prio_msg  <= 1'b0;
            r_pkt_open  <= 1'b0;
            r_tmo       <= 2'd0;
            r_echo_drop <= 1'b0;
        end else begin
            r_echo_drop <= w_drop;
            r_tmo       <= (r_state == WAIT_HI && !tx_busy) ? r_tmo + 2'd1 : 2'd0;
            if (w_pop) begin
                r_tx_data  <= w_head;
                r_prio_msg <= 1'b1;
            end else if (msg_ready) begin
                r_tx_data  <= msg_data;
                r_pkt_open <= !msg_last;
                if (msg_last)
                    r_prio_msg <= 1'b0;
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign echo_drop = r_echo_drop;
    assign o_state   = r_state;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
`ifdef UART_TX_SCHED_ECHO_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       echo_valid = 1'b0;
    logic [7:0] echo_data = 8'h00;
    logic       msg_valid = 1'b0;
    logic [7:0] msg_data = 8'h00;
    logic       msg_last = 1'b0;
    logic       msg_ready, tx_start, echo_drop;
    logic [7:0] tx_data;
    logic [1:0] o_state;
    logic       tx_busy;
    logic       busy_force = 1'b0;
    logic       busy_model = 1'b0;
    int         busy_len = 10;
    int         bcnt = 0;
    logic [7:0] log_q[$];
    logic [8:0] msg_q[$];
    int         msg_acc = 0;
    int         drop_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    assign tx_busy = busy_force | busy_model;
    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .clk(clk), .reset(reset), .echo_valid(echo_valid), .echo_data(echo_data),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last), .msg_ready(msg_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .echo_drop(echo_drop),
        .o_state(o_state)
    );

    // Transmitter model: busy rises one cycle after tx_start and stays high busy_len cycles.
    always @(negedge clk) begin
        if (bcnt > 0) begin
            busy_model = 1'b1;
            bcnt--;
        end else begin
            busy_model = 1'b0;
        end
        if (tx_start === 1'b1) bcnt = busy_len;
    end

    always @(negedge clk) begin
        if (tx_start === 1'b1) log_q.push_back(tx_data);
        if (echo_drop === 1'b1) drop_cnt++;
    end

    always @(posedge clk) if (msg_valid && msg_ready) msg_acc <= msg_acc + 1;

    always @(negedge clk) begin
        if (msg_acc < msg_q.size()) begin
            msg_valid = 1'b1;
            {msg_last, msg_data} = msg_q[msg_acc];
        end else begin
            msg_valid = 1'b0;
            msg_last  = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    task automatic push_echo(input logic [7:0] b);
        @(negedge clk);
        echo_valid = 1'b1;
        echo_data  = b;
        @(negedge clk);
        echo_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && log_q.size() < n; i++) @(negedge clk);
        ok = (log_q.size() >= n);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
        for (int i = 0; i < budget && o_state !== s; i++) @(negedge clk);
        ok = (o_state === s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (msg_ready !== 1'b0) begin n_bad++; $display("FAIL reset_msg_ready: got %b want 0", msg_ready); end
        n_cmp++; if (echo_drop !== 1'b0) begin n_bad++; $display("FAIL reset_echo_drop: got %b want 0", echo_drop); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_echo_latency();
        int base = log_q.size();
        bit ok;
        @(negedge clk);
        echo_valid = 1'b1;
        echo_data  = 8'h41;
        @(negedge clk);
        echo_valid = 1'b0;
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL lat_n1_start: got %b want 0", tx_start); end
        @(negedge clk);
        n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL lat_n2_start: got %b want 1", tx_start); end
        n_cmp++; if (tx_data !== 8'h41) begin n_bad++; $display("FAIL lat_tx_data: got %h want 41", tx_data); end
        n_cmp++; if (o_state !== 2'd1) begin n_bad++; $display("FAIL lat_issue_state: got %0d want 1", o_state); end
        repeat (3) @(negedge clk);
        n_cmp++; if (o_state !== 2'd3) begin n_bad++; $display("FAIL lat_wait_lo: got %0d want 3", o_state); end
        wait_state(2'd0, 40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL lat_back_to_arb: got state %0d want 0", o_state); end
        n_cmp++; if (log_q.size() !== base + 1) begin n_bad++; $display("FAIL lat_start_count: got %0d want %0d", log_q.size(), base + 1); end
    endtask

    task automatic test_full_drop();
        int base = log_q.size();
        int d0 = drop_cnt;
        bit ok;
        logic [7:0] got;
        logic [7:0] exp_b;
        busy_force = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            echo_valid = 1'b1;
            echo_data  = 8'h30 + 8'(i);
        end
        @(negedge clk);
        n_cmp++; if (echo_drop !== 1'b1) begin n_bad++; $display("FAIL full_drop_pulse: got %b want 1", echo_drop); end
        busy_force = 1'b0;
        echo_data  = 8'h3A;
        @(negedge clk);
        echo_valid = 1'b0;
        n_cmp++; if (echo_drop !== 1'b0) begin n_bad++; $display("FAIL push_pop_no_drop: got %b want 0", echo_drop); end
        wait_log(base + DEPTH + 1, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_tx_count: got %0d want %0d", log_q.size() - base, DEPTH + 1); end
        for (int i = 0; i <= DEPTH; i++) begin
            got   = 'x;
            exp_b = (i == DEPTH) ? 8'h3A : 8'h30 + 8'(i);
            if (base + i < log_q.size()) got = log_q[base + i];
            n_cmp++; if (got !== exp_b) begin n_bad++; $display("FAIL full_order[%0d]: got %h want %h", i, got, exp_b); end
        end
        wait_state(2'd0, 40, ok);
        n_cmp++; if (drop_cnt - d0 !== 1) begin n_bad++; $display("FAIL full_drop_count: got %0d want 1", drop_cnt - d0); end
    endtask

    task automatic test_packet_order();
        int base;
        bit ok;
        logic [7:0] got;
        logic [7:0] exp_b[3] = '{8'h48, 8'h49, 8'h21};
        do_reset();
        base = log_q.size();
        msg_q.push_back(9'h048);
        msg_q.push_back(9'h149);
        wait_log(base + 1, 50, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL pkt_first_start: got %0d starts want 1", log_q.size() - base); end
        push_echo(8'h21);
        wait_state(2'd3, 30, ok);
        #1;
        n_cmp++; if (!ok || msg_ready !== 1'b0) begin n_bad++; $display("FAIL pkt_ready_outside_arb: got state %0d ready %b want 3/0", o_state, msg_ready); end
        wait_log(base + 3, 300, ok);
        for (int i = 0; i < 3; i++) begin
            got = 'x;
            if (base + i < log_q.size()) got = log_q[base + i];
            n_cmp++; if (got !== exp_b[i]) begin n_bad++; $display("FAIL pkt_order[%0d]: got %h want %h", i, got, exp_b[i]); end
        end
        wait_state(2'd0, 40, ok);
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        logic [7:0] got;
        logic [7:0] exp_b[8] = '{8'hE0, 8'h61, 8'hE1, 8'h62, 8'hE2, 8'h63, 8'hE3, 8'h64};
        do_reset();
        base = log_q.size();
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) msg_q.push_back(9'h161 + 9'(i));
        push_echo(8'hE0);
        busy_force = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_log(base + 2 * k + 1, 100, ok);
            push_echo(8'hE1 + 8'(k));
        end
        wait_log(base + 8, 400, ok);
        for (int i = 0; i < 8; i++) begin
            got = 'x;
            if (base + i < log_q.size()) got = log_q[base + i];
            n_cmp++; if (got !== exp_b[i]) begin n_bad++; $display("FAIL alt_order[%0d]: got %h want %h", i, got, exp_b[i]); end
        end
        wait_state(2'd0, 40, ok);
    endtask

    task automatic test_timeout();
        int base = log_q.size();
        bit ok;
        logic [7:0] got;
        busy_len = 0;
        @(negedge clk);
        echo_valid = 1'b1;
        echo_data  = 8'h55;
        @(negedge clk);
        echo_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL tmo_start: got %b want 1", tx_start); end
        repeat (4) @(negedge clk);
        n_cmp++; if (o_state !== 2'd2) begin n_bad++; $display("FAIL tmo_still_wait_hi: got %0d want 2", o_state); end
        @(negedge clk);
        n_cmp++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL tmo_back_to_arb: got %0d want 0", o_state); end
        push_echo(8'h56);
        wait_log(base + 2, 30, ok);
        got = 'x;
        if (base + 1 < log_q.size()) got = log_q[base + 1];
        n_cmp++; if (got !== 8'h56) begin n_bad++; $display("FAIL tmo_next_byte: got %h want 56", got); end
        wait_state(2'd0, 40, ok);
        busy_len = 10;
    endtask

    task automatic test_reset_midflight();
        int base = log_q.size();
        bit ok;
        push_echo(8'h70);
        wait_log(base + 1, 30, ok);
        wait_state(2'd3, 30, ok);
        for (int i = 0; i < ((DEPTH < 2) ? DEPTH : 2); i++) push_echo(8'h71 + 8'(i));
        n_cmp++; if (o_state !== 2'd3) begin n_bad++; $display("FAIL mid_pre_state: got %0d want 3", o_state); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL mid_state: got %0d want 0", o_state); end
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (msg_ready !== 1'b0) begin n_bad++; $display("FAIL mid_msg_ready: got %b want 0", msg_ready); end
        n_cmp++; if (echo_drop !== 1'b0) begin n_bad++; $display("FAIL mid_echo_drop: got %b want 0", echo_drop); end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++; if (log_q.size() !== base + 1) begin n_bad++; $display("FAIL mid_no_start_after: got %0d starts want 1", log_q.size() - base); end
        n_cmp++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL mid_idle: got %0d want 0", o_state); end
    endtask

    initial begin
        test_reset();
        test_echo_latency();
        test_full_drop();
        test_packet_order();
        test_back_to_back();
        test_timeout();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
